// File: rtl/seq_shift_unit_if.sv
// seq_shift_unit_if: launch/result bus of the multi-cycle shift engine.
// The sequencer side (master) drives start/in/op/amt and observes the
// result; the engine side (slave) drives out/busy/done.
// SHIFT_CARRY_EN adds the cout signal (last bit shifted out).
interface seq_shift_unit_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic [1:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
`ifdef SHIFT_CARRY_EN
  logic             cout;
`endif

  modport master (
    output start, in, op, amt,
`ifdef SHIFT_CARRY_EN
    input  cout,
`endif
    input  out, busy, done
  );

  modport slave (
    input  start, in, op, amt,
`ifdef SHIFT_CARRY_EN
    output cout,
`endif
    output out, busy, done
  );
endinterface

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle LSL/LSR/ASR engine, one bit position per clock.
// Handshake: start is sampled only in IDLE; busy is high in SHIFT; done is a
// one-cycle pulse with out valid. out holds until the next accepted start.
// Optional feature macro: SHIFT_CARRY_EN (adds cout, the last bit shifted out).
module seq_shift_unit #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  seq_shift_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_LSL  = 2'd1,
    OP_LSR  = 2'd2,
    OP_ASR  = 2'd3
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q,    op_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [AMT_W-1:0] count_q, count_d;
`ifdef SHIFT_CARRY_EN
  logic             cout_q,  cout_d;
`endif

  // Single-position shift of the working register. Amounts >= WIDTH need no
  // special casing: repeated steps drain to zero (LSL/LSR) or all sign bits
  // (ASR) on their own.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                              input op_e o);
    logic [WIDTH-1:0] r;
    case (o)
      OP_LSL:  r = {v[WIDTH-2:0], 1'b0};
      OP_LSR:  r = {1'b0, v[WIDTH-1:1]};
      OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_PASS;
      out_q   <= '0;
      count_q <= '0;
`ifdef SHIFT_CARRY_EN
      cout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      out_q   <= out_d;
      count_q <= count_d;
`ifdef SHIFT_CARRY_EN
      cout_q  <= cout_d;
`endif
    end
  end

  // Next-state and datapath update: capture on accepted start, one step per
  // SHIFT edge, DONE always lasts a single cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    out_d   = out_q;
    count_d = count_q;
`ifdef SHIFT_CARRY_EN
    cout_d  = cout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          out_d   = bus.in;
          count_d = bus.amt;
          op_d    = op_e'(bus.op);
`ifdef SHIFT_CARRY_EN
          cout_d  = 1'b0;
`endif
          // Pass-through and zero-length shifts skip SHIFT entirely.
          if (bus.op == OP_PASS || bus.amt == '0) state_d = ST_DONE;
          else                                    state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        out_d   = shift1(out_q, op_q);
        count_d = count_q - AMT_W'(1);
`ifdef SHIFT_CARRY_EN
        cout_d  = (op_q == OP_LSL) ? out_q[WIDTH-1] : out_q[0];
`endif
        if (count_q == AMT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.out  = out_q;
  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = (state_q == ST_DONE);
`ifdef SHIFT_CARRY_EN
  assign bus.cout = cout_q;
`endif

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed-vector bench for seq_shift_unit.
// Inputs are driven and outputs sampled on the falling edge; "cycle N" is the
// N-th falling edge after the rising edge that sampled start.
module tb_seq_shift_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  seq_shift_unit_if #(.WIDTH(16), .AMT_W(4)) bus ();

  seq_shift_unit #(.WIDTH(16), .AMT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic get_cout();
`ifdef SHIFT_CARRY_EN
    return bus.cout;
`else
    return 1'b0;
`endif
  endfunction

  // Present one start for exactly one rising edge, then scramble the inputs
  // (they must have no effect after acceptance). Returns at cycle 1.
  task automatic launch(input logic [15:0] d, input logic [1:0] o, input logic [3:0] a);
    @(negedge clk);
    bus.start = 1'b1; bus.in = d; bus.op = o; bus.amt = a;
    @(negedge clk);
    bus.start = 1'b0; bus.in = 16'(~d); bus.op = 2'(o + 2'd1); bus.amt = 4'(a + 4'd5);
  endtask

  // Observe an operation from cycle 1 until done (bounded at 64 cycles).
  task automatic run_op(output int cyc, output int bcnt, output logic [15:0] o, output logic c);
    cyc = 1; bcnt = 0;
    while (bus.done !== 1'b1 && cyc < 64) begin
      if (bus.busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
    o = bus.out;
    c = get_cout();
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.in = '0; bus.op = '0; bus.amt = '0;
    repeat (3) @(negedge clk);
    total++; if (bus.out !== 16'h0) begin bad++; $display("FAIL reset_out got=%h exp=0000", bus.out); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
`ifdef SHIFT_CARRY_EN
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_lsl1();
    int cyc, bc; logic [15:0] o; logic c;
    launch(16'hBAB7, 2'd1, 4'd1);
    run_op(cyc, bc, o, c);
    total++; if (cyc !== 2)        begin bad++; $display("FAIL lsl1_lat got=%0d exp=2", cyc); end
    total++; if (bc !== 1)         begin bad++; $display("FAIL lsl1_busy got=%0d exp=1", bc); end
    total++; if (o !== 16'h756E)   begin bad++; $display("FAIL lsl1_out got=%h exp=756e", o); end
`ifdef SHIFT_CARRY_EN
    total++; if (c !== 1'b1)       begin bad++; $display("FAIL lsl1_cout got=%b exp=1", c); end
`endif
    // done is a single-cycle pulse and out holds afterwards
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL lsl1_done_pulse got=%b exp=0", bus.done); end
    total++; if (bus.out !== 16'h756E) begin bad++; $display("FAIL lsl1_hold got=%h exp=756e", bus.out); end
  endtask

  task automatic test_lsr_asr();
    int cyc, bc; logic [15:0] o; logic c;
    launch(16'hBAB7, 2'd2, 4'd4);
    run_op(cyc, bc, o, c);
    total++; if (cyc !== 5)        begin bad++; $display("FAIL lsr4_lat got=%0d exp=5", cyc); end
    total++; if (bc !== 4)         begin bad++; $display("FAIL lsr4_busy got=%0d exp=4", bc); end
    total++; if (o !== 16'h0BAB)   begin bad++; $display("FAIL lsr4_out got=%h exp=0bab", o); end
`ifdef SHIFT_CARRY_EN
    total++; if (c !== 1'b0)       begin bad++; $display("FAIL lsr4_cout got=%b exp=0", c); end
`endif
    launch(16'hBAB7, 2'd3, 4'd4);
    run_op(cyc, bc, o, c);
    total++; if (o !== 16'hFBAB)   begin bad++; $display("FAIL asr4_out got=%h exp=fbab", o); end
    total++; if (cyc !== 5)        begin bad++; $display("FAIL asr4_lat got=%0d exp=5", cyc); end
    launch(16'hBAB7, 2'd2, 4'd1);
    run_op(cyc, bc, o, c);
    total++; if (o !== 16'h5D5B)   begin bad++; $display("FAIL lsr1_out got=%h exp=5d5b", o); end
`ifdef SHIFT_CARRY_EN
    total++; if (c !== 1'b1)       begin bad++; $display("FAIL lsr1_cout got=%b exp=1", c); end
`endif
    // ASR of a positive value fills with zeros
    launch(16'h4000, 2'd3, 4'd3);
    run_op(cyc, bc, o, c);
    total++; if (o !== 16'h0800)   begin bad++; $display("FAIL asr_pos_out got=%h exp=0800", o); end
  endtask

  task automatic test_lsl15();
    int cyc, bc; logic [15:0] o; logic c;
    launch(16'hFFFF, 2'd1, 4'd15);
    run_op(cyc, bc, o, c);
    total++; if (cyc !== 16)       begin bad++; $display("FAIL lsl15_lat got=%0d exp=16", cyc); end
    total++; if (bc !== 15)        begin bad++; $display("FAIL lsl15_busy got=%0d exp=15", bc); end
    total++; if (o !== 16'h8000)   begin bad++; $display("FAIL lsl15_out got=%h exp=8000", o); end
`ifdef SHIFT_CARRY_EN
    total++; if (c !== 1'b1)       begin bad++; $display("FAIL lsl15_cout got=%b exp=1", c); end
`endif
  endtask

  task automatic test_pass_zero();
    int cyc, bc; logic [15:0] o; logic c;
    launch(16'h1234, 2'd0, 4'd7);
    run_op(cyc, bc, o, c);
    total++; if (cyc !== 1)        begin bad++; $display("FAIL pass_lat got=%0d exp=1", cyc); end
    total++; if (bc !== 0)         begin bad++; $display("FAIL pass_busy got=%0d exp=0", bc); end
    total++; if (o !== 16'h1234)   begin bad++; $display("FAIL pass_out got=%h exp=1234", o); end
    launch(16'h1234, 2'd2, 4'd0);
    run_op(cyc, bc, o, c);
    total++; if (cyc !== 1)        begin bad++; $display("FAIL amt0_lat got=%0d exp=1", cyc); end
    total++; if (bc !== 0)         begin bad++; $display("FAIL amt0_busy got=%0d exp=0", bc); end
    total++; if (o !== 16'h1234)   begin bad++; $display("FAIL amt0_out got=%h exp=1234", o); end
`ifdef SHIFT_CARRY_EN
    total++; if (c !== 1'b0)       begin bad++; $display("FAIL amt0_cout got=%b exp=0", c); end
`endif
  endtask

  task automatic test_abort();
    int cyc, bc, seen; logic [15:0] o; logic c;
    launch(16'hFFFF, 2'd2, 4'd8);               // now at cycle 1
    @(negedge clk);                             // cycle 2
    @(negedge clk);                             // cycle 3: second start while busy
    bus.start = 1'b1; bus.in = 16'h1111; bus.op = 2'd1; bus.amt = 4'd1;
    @(negedge clk);                             // cycle 4
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1)  begin bad++; $display("FAIL abort_ignored_busy got=%b exp=1", bus.busy); end
    total++; if (bus.out !== 16'h1FFF) begin bad++; $display("FAIL abort_midway got=%h exp=1fff", bus.out); end
    @(negedge clk);                             // cycle 5: reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (bus.out !== 16'h0)  begin bad++; $display("FAIL abort_out got=%h exp=0000", bus.out); end
    total++; if (bus.busy !== 1'b0)  begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0)         begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    launch(16'h00F0, 2'd2, 4'd4);
    run_op(cyc, bc, o, c);
    total++; if (o !== 16'h000F)     begin bad++; $display("FAIL after_abort_out got=%h exp=000f", o); end
    total++; if (cyc !== 5)          begin bad++; $display("FAIL after_abort_lat got=%0d exp=5", cyc); end
  endtask

  task automatic test_back_to_back();
    int cyc, bc; logic [15:0] o; logic c;
    // start held high: accepted, ignored through SHIFT/DONE, re-accepted in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.in = 16'h8000; bus.op = 2'd3; bus.amt = 4'd2;
    @(negedge clk);                             // cycle 1
    run_op(cyc, bc, o, c);
    total++; if (cyc !== 3)          begin bad++; $display("FAIL b2b_first_lat got=%0d exp=3", cyc); end
    total++; if (o !== 16'hE000)     begin bad++; $display("FAIL b2b_first_out got=%h exp=e000", o); end
    bus.in = 16'h0001; bus.op = 2'd1; bus.amt = 4'd3;
    @(negedge clk);                             // IDLE cycle, start still high
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin bad++; $display("FAIL b2b_idle got=%b%b exp=00", bus.busy, bus.done); end
    total++; if (bus.out !== 16'hE000) begin bad++; $display("FAIL b2b_idle_hold got=%h exp=e000", bus.out); end
    @(negedge clk);                             // cycle 1 of second op
    bus.start = 1'b0;
    run_op(cyc, bc, o, c);
    total++; if (cyc !== 4)          begin bad++; $display("FAIL b2b_second_lat got=%0d exp=4", cyc); end
    total++; if (o !== 16'h0008)     begin bad++; $display("FAIL b2b_second_out got=%h exp=0008", o); end
  endtask

  initial begin
    test_reset();
    test_lsl1();
    test_lsr_asr();
    test_lsl15();
    test_pass_zero();
    test_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case something wedges the stimulus itself.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
